// File: rtl/apb_add_master.sv
// APB master that adds two operands on an external adder slave: writes op_a, writes op_b,
// reads the sum back. Each APB transfer is SETUP then ACCESS; ACCESS waits are bounded by TIMEOUT.
module apb_add_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PRWADDR,
    output logic [31:0] PRWDATA,
    output logic [1:0]  f,
    input  logic [31:0] PRDATA1,
    input  logic        PREADY,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE, SETUP_A, ACCESS_A, SETUP_B, ACCESS_B, SETUP_S, ACCESS_S, DONE
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [7:0]  wait_cnt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        in_access;
    logic        in_setup;
    logic        timeout_hit;

    assign state_dbg = state;

    always_comb begin
        in_access   = (state == ACCESS_A) || (state == ACCESS_B) || (state == ACCESS_S);
        in_setup    = (state == SETUP_A) || (state == SETUP_B) || (state == SETUP_S);
        // This cycle is the TIMEOUT-th ACCESS cycle without PREADY.
        timeout_hit = in_access && !PREADY && (wait_cnt == 8'(TIMEOUT - 1));
        nxt = state;
        case (state)
            IDLE:     if (start) nxt = SETUP_A;
            SETUP_A:  nxt = ACCESS_A;
            ACCESS_A: if (PREADY) nxt = SETUP_B; else if (timeout_hit) nxt = DONE;
            SETUP_B:  nxt = ACCESS_B;
            ACCESS_B: if (PREADY) nxt = SETUP_S; else if (timeout_hit) nxt = DONE;
            SETUP_S:  nxt = ACCESS_S;
            ACCESS_S: if (PREADY || timeout_hit) nxt = DONE;
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            result   <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PRWADDR  <= 32'd0;
            PRWDATA  <= 32'd0;
            f        <= 2'b00;
        end else begin
            state <= nxt;
            if (state == IDLE && start) begin
                a_q <= op_a;
                b_q <= op_b;
            end
            if (in_setup)
                wait_cnt <= 8'd0;
            else if (in_access && !PREADY)
                wait_cnt <= wait_cnt + 8'd1;
            if (state == ACCESS_S && PREADY)
                result <= PRDATA1;

            busy    <= (nxt != IDLE);
            done    <= (nxt == DONE);
            err     <= timeout_hit;
            PSEL    <= (nxt != IDLE) && (nxt != DONE);
            PENABLE <= (nxt == ACCESS_A) || (nxt == ACCESS_B) || (nxt == ACCESS_S);

            // Bus fields are set from the state being entered so they are stable for the whole transfer.
            case (nxt)
                SETUP_A: begin
                    PWRITE <= 1'b1; PRWADDR <= 32'd0; PRWDATA <= op_a; f <= 2'b01;
                end
                ACCESS_A: begin
                    PWRITE <= 1'b1; PRWADDR <= 32'd0; PRWDATA <= a_q;  f <= 2'b01;
                end
                SETUP_B, ACCESS_B: begin
                    PWRITE <= 1'b1; PRWADDR <= 32'd1; PRWDATA <= b_q;  f <= 2'b10;
                end
                SETUP_S, ACCESS_S: begin
                    PWRITE <= 1'b0; PRWADDR <= 32'd2; PRWDATA <= 32'd0; f <= 2'b11;
                end
                default: begin
                    PWRITE <= 1'b0; PRWADDR <= 32'd0; PRWDATA <= 32'd0; f <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_add_master.sv
// Self-checking bench for apb_add_master with a registered-PREADY adder slave model.
module tb_apb_add_master;

  localparam int TIMEOUT = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PRWADDR;
  logic [31:0] PRWDATA;
  logic [1:0]  f;
  logic [31:0] PRDATA1;
  logic        PREADY;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad = 0;

  // scoreboard of expected results, and the last successful sum
  logic [31:0] exp_q[$];
  logic [31:0] exp_result = 32'd0;

  apb_add_master #(.TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .err(err), .result(result),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PRWADDR(PRWADDR),
    .PRWDATA(PRWDATA), .f(f), .PRDATA1(PRDATA1), .PREADY(PREADY),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 PCLK = ~PCLK;

  // adder slave: registered PREADY raised after w_arr[addr] extra ACCESS cycles
  logic [31:0] s_a = 32'd0;
  logic [31:0] s_b = 32'd0;
  int          w_arr[4];
  bit          tie_low = 1'b0;
  int          acc_cnt = 0;

  assign PRDATA1 = s_a + s_b;

  always @(posedge PCLK) begin
    if (PRESET || !(PSEL && PENABLE)) begin
      PREADY  <= 1'b0;
      acc_cnt <= 0;
    end else if (PREADY) begin
      PREADY  <= 1'b0;
      acc_cnt <= 0;
      if (PWRITE && PRWADDR == 32'd0) s_a <= PRWDATA;
      if (PWRITE && PRWADDR == 32'd1) s_b <= PRWDATA;
    end else if (!tie_low && acc_cnt >= w_arr[PRWADDR[1:0]]) begin
      PREADY <= 1'b1;
    end else begin
      acc_cnt <= acc_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    start = 1'b0;
    op_a = 32'd0;
    op_b = 32'd0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    exp_result = 32'd0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_psel"}, PSEL, 1'b0);
    check({tag, "_penable"}, PENABLE, 1'b0);
    check({tag, "_pwrite"}, PWRITE, 1'b0);
    check({tag, "_addr"}, PRWADDR, 32'd0);
    check({tag, "_wdata"}, PRWDATA, 32'd0);
    check({tag, "_f"}, f, 2'b00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  // One command: cycle 1 is the cycle after the edge that samples start.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int w0, input int w1, input int w2,
                        input bit tie, input bit inject);
    int cyc;
    int exp_cycles;
    int nf;
    logic [5:0] fseq;
    logic [1:0] last_f;
    bit injected;
    logic [31:0] exp_sum;
    w_arr[0] = w0; w_arr[1] = w1; w_arr[2] = w2; w_arr[3] = 0;
    tie_low = tie;
    exp_sum = tie ? exp_result : a + b;
    exp_q.push_back(exp_sum);
    exp_cycles = tie ? 2 + TIMEOUT : 1 + (3 + w0) + (3 + w1) + (3 + w2);
    nf = 0; fseq = 6'd0; last_f = 2'b00; injected = 1'b0;

    start = 1'b1; op_a = a; op_b = b;
    @(posedge PCLK);
    @(negedge PCLK);
    start = 1'b0;
    op_a = $urandom; op_b = $urandom;
    cyc = 1;
    while (!done && cyc < exp_cycles + 20) begin
      if (start) start = 1'b0;
      check("busy_mid", busy, 1'b1);
      if (PSEL) begin
        if (nf == 0 || f != last_f) begin
          fseq = {fseq[3:0], f};
          nf++;
          last_f = f;
        end
        case (f)
          2'b01: begin
            check("a_addr", PRWADDR, 32'd0);
            check("a_wdata", PRWDATA, a);
            check("a_pwrite", PWRITE, 1'b1);
          end
          2'b10: begin
            check("b_addr", PRWADDR, 32'd1);
            check("b_wdata", PRWDATA, b);
            check("b_pwrite", PWRITE, 1'b1);
          end
          2'b11: begin
            check("s_addr", PRWADDR, 32'd2);
            check("s_wdata", PRWDATA, 32'd0);
            check("s_pwrite", PWRITE, 1'b0);
          end
          default: check("f_nonzero", f != 2'b00, 1'b1);
        endcase
        if (inject && !injected && !PENABLE && f == 2'b10) begin
          start = 1'b1;
          op_a = $urandom;
          op_b = $urandom;
          injected = 1'b1;
        end
      end
      @(negedge PCLK);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    check("done_latency", cyc, exp_cycles);
    check("err", err, tie);
    check("result", result, exp_q.pop_front());
    check("done_psel", PSEL, 1'b0);
    check("done_penable", PENABLE, 1'b0);
    check("done_f", f, 2'b00);
    check("done_busy", busy, 1'b1);
    check("fseq", {26'd0, fseq}, tie ? 32'd1 : 32'h1B);
    if (inject) check("inject_seen", injected, 1'b1);
    if (!tie) exp_result = exp_sum;
    @(negedge PCLK);
    check_idle_outputs("after_done");
    // a start seen outside IDLE must not produce a second command
    repeat (3) @(negedge PCLK);
    check("no_extra_busy", busy, 1'b0);
    check("result_held", result, exp_result);
  endtask

  task automatic run_reset_mid_b();
    int guard;
    int dones;
    w_arr[0] = 0; w_arr[1] = 3; w_arr[2] = 0; w_arr[3] = 0;
    tie_low = 1'b0;
    start = 1'b1; op_a = 32'd99; op_b = 32'd1;
    @(posedge PCLK);
    @(negedge PCLK);
    start = 1'b0;
    guard = 0;
    while (!(PSEL && PENABLE && f == 2'b10) && guard < 40) begin
      @(negedge PCLK);
      guard++;
    end
    check("reached_access_b", PSEL && PENABLE && f == 2'b10, 1'b1);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    exp_result = 32'd0;
    check_idle_outputs("rst_b");
    check("rst_b_result", result, 32'd0);
    check("rst_b_err", err, 1'b0);
    dones = 0;
    repeat (15) begin
      @(negedge PCLK);
      if (done) dones++;
    end
    check("rst_b_no_done", dones, 0);
  endtask

  initial begin
    do_reset();
    check_idle_outputs("reset");
    check("reset_result", result, 32'd0);
    check("reset_err", err, 1'b0);

    run_op(32'd3, 32'd5, 0, 0, 0, 1'b0, 1'b0);
    run_op(32'd7, 32'd9, 0, 0, 0, 1'b1, 1'b0);
    run_op(32'hFFFFFFFF, 32'd1, 0, 0, 0, 1'b0, 1'b0);
    run_op(32'd40, 32'd2, 1, 0, 2, 1'b0, 1'b0);
    run_reset_mid_b();
    run_op(32'd10, 32'd20, 0, 0, 0, 1'b0, 1'b0);
    run_op(32'd11, 32'd22, 0, 1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      run_op(32'd123456, 32'd654321, $urandom_range(0, 5), $urandom_range(0, 5),
             $urandom_range(0, 5), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op($urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 5),
             $urandom_range(0, 5), 1'b0, 1'b0);
    run_op($urandom, $urandom, 0, 0, 0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
